// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and load/store.
// Only one transaction is in flight at a time. Ties are broken round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                dm_req_valid,
  input  logic                dm_req_we,
  input  logic [ADDR_W-1:0]   dm_req_addr,
  input  logic [DATA_W-1:0]   dm_req_wdata,
  input  logic [DATA_W/8-1:0] dm_req_wmask,
  output logic                dm_req_ready,
  output logic                dm_rsp_valid,
  output logic [DATA_W-1:0]   dm_rsp_data,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic       GNT_IF = 1'b0;
  localparam logic       GNT_DM = 1'b1;
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic                op_we_q, op_we_d;
  logic                if_rsp_valid_q, if_rsp_valid_d;
  logic                dm_rsp_valid_q, dm_rsp_valid_d;
  logic [DATA_W-1:0]   if_rsp_data_q, if_rsp_data_d;
  logic [DATA_W-1:0]   dm_rsp_data_q, dm_rsp_data_d;
  logic                gnt_if_s, gnt_dm_s;

  // The requester that was not granted last wins a tie.
  always_comb begin
    gnt_if_s = if_req_valid & (~dm_req_valid | (last_grant_q == GNT_DM));
    gnt_dm_s = dm_req_valid & (~if_req_valid | (last_grant_q == GNT_IF));
  end

  // Next-state, memory strobe and handshake decode.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_grant_d   = last_grant_q;
    owner_d        = owner_q;
    op_we_d        = op_we_q;
    if_rsp_valid_d = 1'b0;
    dm_rsp_valid_d = 1'b0;
    if_rsp_data_d  = if_rsp_data_q;
    dm_rsp_data_d  = dm_rsp_data_q;
    if_req_ready   = 1'b0;
    dm_req_ready   = 1'b0;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = {ADDR_W{1'b0}};
    mem_wdata      = {DATA_W{1'b0}};
    mem_wmask      = {(DATA_W/8){1'b0}};

    if (rst) begin
      case (state_q)
        S_IDLE: begin
          if (gnt_if_s) begin
            if_req_ready = 1'b1;
            mem_en       = 1'b1;
            mem_addr     = if_req_addr;
            owner_d      = GNT_IF;
            op_we_d      = 1'b0;
            last_grant_d = GNT_IF;
            cnt_d        = LAT_M1;
            state_d      = S_WAIT;
          end else if (gnt_dm_s) begin
            dm_req_ready = 1'b1;
            mem_en       = 1'b1;
            mem_we       = dm_req_we;
            mem_addr     = dm_req_addr;
            mem_wdata    = dm_req_wdata;
            mem_wmask    = dm_req_wmask;
            owner_d      = GNT_DM;
            op_we_d      = dm_req_we;
            last_grant_d = GNT_DM;
            cnt_d        = LAT_M1;
            state_d      = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_d = S_IDLE;
            if (owner_q == GNT_IF) begin
              if_rsp_valid_d = 1'b1;
              if_rsp_data_d  = mem_rdata;
            end else begin
              dm_rsp_valid_d = 1'b1;
              dm_rsp_data_d  = op_we_q ? {DATA_W{1'b0}} : mem_rdata;
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = S_IDLE;
    end
  end

  // State and response registers; a reset in WAIT drops the transaction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= 4'd0;
      last_grant_q   <= GNT_DM;
      owner_q        <= GNT_IF;
      op_we_q        <= 1'b0;
      if_rsp_valid_q <= 1'b0;
      dm_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= {DATA_W{1'b0}};
      dm_rsp_data_q  <= {DATA_W{1'b0}};
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_grant_q   <= last_grant_d;
      owner_q        <= owner_d;
      op_we_q        <= op_we_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      dm_rsp_valid_q <= dm_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      dm_rsp_data_q  <= dm_rsp_data_d;
    end
  end

  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_data  = if_rsp_data_q;
  assign dm_rsp_valid = dm_rsp_valid_q;
  assign dm_rsp_data  = dm_rsp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=2 instance with a small memory
// model, plus a MEM_LAT=1 instance for the short-latency build.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          if_req_valid, if_req_ready, if_rsp_valid;
  logic [AW-1:0] if_req_addr;
  logic [DW-1:0] if_rsp_data;
  logic          dm_req_valid, dm_req_we, dm_req_ready, dm_rsp_valid;
  logic [AW-1:0] dm_req_addr;
  logic [DW-1:0] dm_req_wdata, dm_rsp_data;
  logic [3:0]    dm_req_wmask;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_wmask;

  logic          b_if_req_valid, b_if_req_ready, b_if_rsp_valid;
  logic [AW-1:0] b_if_req_addr;
  logic [DW-1:0] b_if_rsp_data;
  logic          b_dm_req_valid, b_dm_req_we, b_dm_req_ready, b_dm_rsp_valid;
  logic [AW-1:0] b_dm_req_addr;
  logic [DW-1:0] b_dm_req_wdata, b_dm_rsp_data;
  logic [3:0]    b_dm_req_wmask;
  logic          b_mem_en, b_mem_we;
  logic [AW-1:0] b_mem_addr;
  logic [DW-1:0] b_mem_wdata, b_mem_rdata;
  logic [3:0]    b_mem_wmask;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .dm_req_valid(dm_req_valid), .dm_req_we(dm_req_we), .dm_req_addr(dm_req_addr),
    .dm_req_wdata(dm_req_wdata), .dm_req_wmask(dm_req_wmask), .dm_req_ready(dm_req_ready),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req_valid(b_if_req_valid), .if_req_addr(b_if_req_addr), .if_req_ready(b_if_req_ready),
    .if_rsp_valid(b_if_rsp_valid), .if_rsp_data(b_if_rsp_data),
    .dm_req_valid(b_dm_req_valid), .dm_req_we(b_dm_req_we), .dm_req_addr(b_dm_req_addr),
    .dm_req_wdata(b_dm_req_wdata), .dm_req_wmask(b_dm_req_wmask), .dm_req_ready(b_dm_req_ready),
    .dm_rsp_valid(b_dm_rsp_valid), .dm_rsp_data(b_dm_rsp_data),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wmask(b_mem_wmask), .mem_rdata(b_mem_rdata)
  );

  // Word memory with a LAT-deep read pipeline; idle cycles return a poison word.
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] pipe [0:LAT-1];
  always @(posedge clk) begin
    if (!rst) mem[4] <= 32'h0050_0093;
    if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    pipe[0] <= mem_en ? mem[mem_addr[9:2]] : 32'hBAD0_BAD0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  always @(posedge clk) b_mem_rdata <= b_mem_en ? 32'h1234_5678 : 32'hBAD0_BAD0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_addr = 32'h100;
    dm_req_wdata = 32'h0; dm_req_wmask = 4'h0;
    b_if_req_valid = 1'b0; b_if_req_addr = 32'h0; b_dm_req_valid = 1'b0; b_dm_req_we = 1'b0;
    b_dm_req_addr = 32'h0; b_dm_req_wdata = 32'h0; b_dm_req_wmask = 4'h0;
    tick; tick; #1;
    tests++;
    if ({if_req_ready, dm_req_ready, mem_en} !== 3'b000) begin
      fails++; $display("FAIL reset_ready_en: got %b want 000", {if_req_ready, dm_req_ready, mem_en});
    end
    tests++;
    if ({if_rsp_valid, dm_rsp_valid, if_rsp_data, dm_rsp_data} !== 66'h0) begin
      fails++; $display("FAIL reset_rsp: got %b %b %h %h want 0", if_rsp_valid, dm_rsp_valid, if_rsp_data, dm_rsp_data);
    end
    tick;
    if_req_valid = 1'b0; dm_req_valid = 1'b0; rst = 1'b1;
  endtask

  task automatic test_single_fetch;
    tick;
    if_req_valid = 1'b1; if_req_addr = 32'h0000_0010;
    #1;
    tests++;
    if ({if_req_ready, dm_req_ready, mem_en, mem_we, mem_wmask} !== 8'b1010_0000) begin
      fails++; $display("FAIL fetch_hs: got %b want 10100000", {if_req_ready, dm_req_ready, mem_en, mem_we, mem_wmask});
    end
    tests++;
    if (mem_addr !== 32'h10) begin
      fails++; $display("FAIL fetch_addr: got %h want 00000010", mem_addr);
    end
    tick;
    if_req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) tick;
      #1;
      tests++;
      if ({if_rsp_valid, dm_rsp_valid, mem_en} !== {(c == 3), 1'b0, 1'b0}) begin
        fails++; $display("FAIL fetch_rsp_c%0d: got %b want %b", c, {if_rsp_valid, dm_rsp_valid, mem_en}, {(c == 3), 2'b00});
      end
      if (c >= 3) begin
        tests++;
        if (if_rsp_data !== 32'h0050_0093) begin
          fails++; $display("FAIL fetch_data_c%0d: got %h want 00500093", c, if_rsp_data);
        end
      end
    end
  endtask

  task automatic test_store_load;
    tick;
    dm_req_valid = 1'b1; dm_req_we = 1'b1; dm_req_addr = 32'h100;
    dm_req_wdata = 32'hDEAD_BEEF; dm_req_wmask = 4'hF;
    #1;
    tests++;
    if ({if_req_ready, dm_req_ready, mem_en, mem_we, mem_wmask} !== 8'b0111_1111) begin
      fails++; $display("FAIL store_hs: got %b want 01111111", {if_req_ready, dm_req_ready, mem_en, mem_we, mem_wmask});
    end
    tests++;
    if ({mem_addr, mem_wdata} !== {32'h100, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL store_fields: got %h %h want 00000100 deadbeef", mem_addr, mem_wdata);
    end
    tick;
    dm_req_valid = 1'b0;
    tick;
    #1;
    tests++;
    if (dm_rsp_valid !== 1'b0) begin
      fails++; $display("FAIL store_early_rsp: got %b want 0", dm_rsp_valid);
    end
    tick;
    dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_wdata = 32'h0; dm_req_wmask = 4'h0;
    #1;
    tests++;
    if ({dm_rsp_valid, if_rsp_valid, dm_rsp_data} !== {2'b10, 32'h0}) begin
      fails++; $display("FAIL store_ack: got %b %b %h want 1 0 00000000", dm_rsp_valid, if_rsp_valid, dm_rsp_data);
    end
    tests++;
    if ({dm_req_ready, mem_en, mem_we} !== 3'b110) begin
      fails++; $display("FAIL load_hs: got %b want 110", {dm_req_ready, mem_en, mem_we});
    end
    tick;
    dm_req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) tick;
      #1;
      tests++;
      if (dm_rsp_valid !== (c == 3)) begin
        fails++; $display("FAIL load_rsp_c%0d: got %b want %b", c, dm_rsp_valid, (c == 3));
      end
    end
    tests++;
    if (dm_rsp_data !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL load_data: got %h want deadbeef", dm_rsp_data);
    end
  endtask

  task automatic test_back_to_back;
    tick;
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) tick;
      if (c == 9) if_req_valid = 1'b0;
      #1;
      tests++;
      if ({mem_en, if_req_ready, if_rsp_valid} !==
          {(c % 3 == 0 && c < 9), (c % 3 == 0 && c < 9), (c > 0 && c % 3 == 0)}) begin
        fails++; $display("FAIL b2b_c%0d: got %b want %b", c, {mem_en, if_req_ready, if_rsp_valid},
                          {(c % 3 == 0 && c < 9), (c % 3 == 0 && c < 9), (c > 0 && c % 3 == 0)});
      end
    end
  endtask

  task automatic test_contention;
    int  ng;
    int  ng_if;
    int  ng_dm;
    int  k;
    logic drop_if;
    logic drop_dm;
    ng = 0; ng_if = 0; ng_dm = 0; drop_if = 1'b0; drop_dm = 1'b0;
    tick;
    rst = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_addr = 32'h100; dm_req_wmask = 4'h0;
    tick;
    rst = 1'b1;
    for (int c = 0; c < 26; c++) begin
      if (c > 0) tick;
      if (drop_if) if_req_valid = 1'b0;
      if (drop_dm) dm_req_valid = 1'b0;
      #1;
      tests++;
      if (if_req_ready && dm_req_ready) begin
        fails++; $display("FAIL cont_both_ready_c%0d: got 11 want not both", c);
      end
      if (c >= 3 && c <= 24 && c % 3 == 0) begin
        k = c / 3 - 1;
        tests++;
        if ({if_rsp_valid, dm_rsp_valid} !== {(k % 2 == 0), (k % 2 == 1)}) begin
          fails++; $display("FAIL cont_rsp_c%0d: got %b%b want %b%b", c, if_rsp_valid, dm_rsp_valid, (k % 2 == 0), (k % 2 == 1));
        end
        tests++;
        if ((k % 2 == 0) ? (if_rsp_data !== 32'h0050_0093) : (dm_rsp_data !== 32'hDEAD_BEEF)) begin
          fails++; $display("FAIL cont_data_c%0d: got %h/%h want 00500093/deadbeef", c, if_rsp_data, dm_rsp_data);
        end
      end else begin
        tests++;
        if ({if_rsp_valid, dm_rsp_valid} !== 2'b00) begin
          fails++; $display("FAIL cont_norsp_c%0d: got %b%b want 00", c, if_rsp_valid, dm_rsp_valid);
        end
      end
      if (if_req_ready || dm_req_ready) begin
        tests++;
        if (c != 3 * ng || ng >= 8 || dm_req_ready !== (ng % 2 == 1)) begin
          fails++; $display("FAIL cont_grant%0d: got cycle %0d dm=%b want cycle %0d dm=%b", ng, c, dm_req_ready, 3 * ng, (ng % 2 == 1));
        end
        if (if_req_ready) ng_if++;
        if (dm_req_ready) ng_dm++;
        ng++;
        drop_if = (ng_if >= 4);
        drop_dm = (ng_dm >= 4);
      end
    end
    tests++;
    if (ng != 8) begin
      fails++; $display("FAIL cont_count: got %0d want 8", ng);
    end
    if_req_valid = 1'b0; dm_req_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    tick;
    dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_addr = 32'h100;
    #1;
    tests++;
    if ({dm_req_ready, mem_en} !== 2'b11) begin
      fails++; $display("FAIL rmid_hs: got %b want 11", {dm_req_ready, mem_en});
    end
    tick;
    rst = 1'b0; if_req_valid = 1'b1; if_req_addr = 32'h10;
    #1;
    tests++;
    if ({if_req_ready, dm_req_ready, mem_en} !== 3'b000) begin
      fails++; $display("FAIL rmid_in_reset: got %b want 000", {if_req_ready, dm_req_ready, mem_en});
    end
    tick;
    rst = 1'b1;
    #1;
    tests++;
    if ({if_req_ready, dm_req_ready, mem_en} !== 3'b101 || mem_addr !== 32'h10) begin
      fails++; $display("FAIL rmid_tie: got %b %h want 101 00000010", {if_req_ready, dm_req_ready, mem_en}, mem_addr);
    end
    tick;
    if_req_valid = 1'b0;
    for (int c = 3; c <= 4; c++) begin
      if (c > 3) tick;
      #1;
      tests++;
      if ({dm_rsp_valid, dm_rsp_data} !== 33'h0) begin
        fails++; $display("FAIL rmid_norsp_c%0d: got %b %h want 0 00000000", c, dm_rsp_valid, dm_rsp_data);
      end
    end
    tick;
    #1;
    tests++;
    if ({if_rsp_valid, dm_rsp_valid, dm_req_ready} !== 3'b101 || if_rsp_data !== 32'h0050_0093) begin
      fails++; $display("FAIL rmid_after: got %b %h want 101 00500093", {if_rsp_valid, dm_rsp_valid, dm_req_ready}, if_rsp_data);
    end
    tick;
    dm_req_valid = 1'b0;
    tick; tick;
    #1;
    tests++;
    if ({dm_rsp_valid, dm_rsp_data} !== {1'b1, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL rmid_dm_load: got %b %h want 1 deadbeef", dm_rsp_valid, dm_rsp_data);
    end
  endtask

  task automatic test_lat1;
    tick;
    b_if_req_valid = 1'b1; b_if_req_addr = 32'h20;
    #1;
    tests++;
    if ({b_if_req_ready, b_mem_en} !== 2'b11 || b_mem_addr !== 32'h20) begin
      fails++; $display("FAIL lat1_hs: got %b %h want 11 00000020", {b_if_req_ready, b_mem_en}, b_mem_addr);
    end
    tick;
    #1;
    tests++;
    if ({b_if_req_ready, b_mem_en, b_if_rsp_valid} !== 3'b000) begin
      fails++; $display("FAIL lat1_wait: got %b want 000", {b_if_req_ready, b_mem_en, b_if_rsp_valid});
    end
    tick;
    #1;
    tests++;
    if ({b_if_rsp_valid, b_if_req_ready, b_mem_en} !== 3'b111 || b_if_rsp_data !== 32'h1234_5678) begin
      fails++; $display("FAIL lat1_rsp: got %b %h want 111 12345678", {b_if_rsp_valid, b_if_req_ready, b_mem_en}, b_if_rsp_data);
    end
    tick;
    b_if_req_valid = 1'b0;
    #1;
    tests++;
    if ({b_if_rsp_valid, b_dm_rsp_valid} !== 2'b00) begin
      fails++; $display("FAIL lat1_pulse: got %b want 00", {b_if_rsp_valid, b_dm_rsp_valid});
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_load();
    test_back_to_back();
    test_contention();
    test_reset_mid();
    test_lat1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the processor's single unified memory port between the instruction-fetch requester and the load/store (data memory) requester. One transaction is in flight at a time, and the memory has a fixed read latency. Requests use a valid/ready handshake. Competing requests are granted round-robin, and each response is routed back to the requester that issued it. The block sits between the DataPath's fetch/LSU request interfaces and the memory macro.

## Interface
Parameters:
- ADDR_W, 32, request/memory address width
- DATA_W, 32, data width; wmask width is DATA_W/8
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range 1..15

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- if_req_valid  in  1  fetch request pending (read only)
- if_req_addr  in  ADDR_W  fetch address
- if_req_ready  out  1  fetch request accepted this cycle
- if_rsp_valid  out  1  one-cycle pulse; if_rsp_data valid
- if_rsp_data  out  DATA_W  fetched word
- dm_req_valid  in  1  data request pending
- dm_req_we  in  1  1 = store, 0 = load
- dm_req_addr  in  ADDR_W  data address
- dm_req_wdata  in  DATA_W  store data
- dm_req_wmask  in  DATA_W/8  byte enables for store
- dm_req_ready  out  1  data request accepted this cycle
- dm_rsp_valid  out  1  one-cycle pulse; load data or store acknowledge
- dm_rsp_data  out  DATA_W  load data; 0 for store acknowledge
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wmask  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

## Operation
- FSM states: IDLE, WAIT.
- IDLE: arbitrate among valid requesters. If exactly one requester is valid, it is granted. If both are valid, the requester not granted last is granted.
- The last_grant register resets to DM, so IF wins the first tie.
- The granted requester's ready is high combinationally in IDLE. The non-granted ready is 0. Ready is never high in WAIT.
- Handshake occurs when valid & ready. In the handshake cycle:
  - mem_en = 1; mem_addr, mem_we, mem_wdata, mem_wmask come combinationally from the granted request.
  - The IF path drives mem_we = 0 and mem_wmask = 0.
  - last_grant, owner and op type are registered, the latency counter is loaded with MEM_LAT-1, and the state moves to WAIT.
- WAIT: mem_en = 0 and all other mem_* outputs = 0. The counter decrements each cycle.
  - When counter = 0, mem_rdata is captured into the owner's rsp_data register (0 if the op was a store) and the owner's rsp_valid is set for the next cycle. The state returns to IDLE.
- A requester must hold valid and all request fields stable until ready. Dropping valid before ready is illegal and unchecked.
- rsp_valid is a single-cycle pulse; rsp_data holds its value until the next response to that requester.
- The two rsp_valid outputs are never high in the same cycle.
- Reset (rst = 0 at a clock edge): state → IDLE, counter → 0, last_grant → DM, both rsp_valid → 0, both rsp_data → 0.
  - Reset in WAIT aborts the transaction: no response pulse is produced and the memory result is discarded.
  - During reset, both ready outputs are 0 and mem_en = 0.

## Timing
- Handshake in cycle T: mem_en high in T only.
- mem_rdata is sampled at the end of cycle T+MEM_LAT.
- rsp_valid is high in cycle T+MEM_LAT+1, when the FSM is already back in IDLE.
- Accept-to-response latency is MEM_LAT+1 cycles.
- A new handshake may occur in the same cycle as the previous response pulse.
- Peak throughput is one transaction per MEM_LAT+1 cycles.
- With continuous contention, grants strictly alternate IF, DM, IF, DM.
- Reset values: if_req_ready/dm_req_ready follow IDLE arbitration after reset is released. All other outputs are 0.

## Test plan
- Single fetch, MEM_LAT=2:
  - Stimulus: if_req_valid with addr 0x0000_0010 at T; memory returns 0x00500093 at T+2.
  - Required: if_req_ready=1 at T; mem_en=1 and mem_addr=0x10 at T; if_rsp_valid=1 with data 0x00500093 at T+3 only; dm_rsp_valid stays 0.
- Store then load:
  - Stimulus: store of 0xDEADBEEF to 0x100 with mask 0xF, then a load from 0x100.
  - Required: the store shows mem_we=1, mem_wmask=0xF and produces a dm_rsp_valid pulse with data 0. The load returns 0xDEADBEEF 3 cycles after its handshake.
- Contention:
  - Stimulus: if_req_valid and dm_req_valid held high for 4 transactions each, starting from reset.
  - Required: grant order IF, DM, IF, DM, …; handshakes spaced exactly 3 cycles apart; no cycle with both readies high.
- Back-to-back:
  - Stimulus: a new IF request is presented in the cycle of the previous if_rsp_valid pulse.
  - Required: handshake occurs in that same cycle; mem_en is asserted once every 3 cycles.
- Reset mid-transaction:
  - Stimulus: rst=0 for 1 cycle at T+1 after a DM load handshake at T.
  - Required: no dm_rsp_valid pulse; dm_rsp_data=0; the next request after reset is accepted in IDLE, with IF winning any tie.
- MEM_LAT=1 build:
  - Stimulus: fetch handshake at T.
  - Required: rsp_valid at T+2; a second request is accepted at T+2.
